gnn_result_collector: RTL and testbench

- Consumer end of the GNN top's result interface.
- Arms the top by driving in_ready, waits for all per-node output-ready flags, and snapshots the eight 21-bit results into a shadow buffer.
- Streams the snapshot out one word per beat over a valid/ready master port.
- Sits between the GNN top and the downstream host or result FIFO, so the top can be re-armed for the next graph while results drain.

---
 rtl/gnn_pkg.sv | 28 ++
 rtl/gnn_result_buf.sv | 34 +++
 rtl/gnn_result_collector.sv | 150 +++++++++++++++
 tb/tb_gnn_result_collector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_pkg.sv
//------------------------------------------------------------------------------
// Module : gnn_pkg
// Brief  : Shared constants, result word type and FSM state enum for the
//          GNN result collector.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gnn_pkg;

    localparam int NUM_NODES   = 4;
    localparam int NUM_OUTS    = 2;
    localparam int OUT_W       = 21;
    localparam int NUM_WORDS   = NUM_NODES * NUM_OUTS;
    localparam int IDX_W       = $clog2(NUM_WORDS);
    localparam int TIMEOUT_CYC = 64;

    typedef logic signed [OUT_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gnn_result_buf.sv
//------------------------------------------------------------------------------
// Module : gnn_result_buf
// Brief  : Shadow register file holding one snapshot of all result words;
//          parallel load, indexed combinational read.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gnn_result_buf
    import gnn_pkg::*;
(
    input  logic                       clk,
    input  logic                       load,
    input  logic [NUM_WORDS*OUT_W-1:0] load_data,
    input  logic [IDX_W-1:0]           rd_idx,
    output word_t                      rd_data
);

    word_t mem [NUM_WORDS];

    // Datapath only: contents are meaningless until the first capture.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                mem[k] <= word_t'(load_data[k*OUT_W +: OUT_W]);
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/gnn_result_collector.sv
//------------------------------------------------------------------------------
// Module : gnn_result_collector
// Brief  : Arms the GNN top, snapshots all results once every ready flag is
//          high, then streams them out one word per valid/ready beat.
//          Optional ARM timeout enabled by GNN_COLLECTOR_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gnn_result_collector
    import gnn_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_WORDS*OUT_W-1:0] res_data,
    input  logic [NUM_WORDS-1:0]       res_ready,
    output logic                       in_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic [IDX_W-1:0]           m_idx,
    output logic                       m_last,
    output logic                       busy,
    output logic                       timeout_err
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic             start_pending;
    logic             all_ready;
    logic             capture;
    word_t            buf_rd;

    assign all_ready = &res_ready;
    assign capture   = (state == ST_ARM) && all_ready;
    assign ptr_nxt   = ptr + 1'b1;

    gnn_result_buf u_buf (
        .clk       (clk),
        .load      (capture),
        .load_data (res_data),
        .rd_idx    (ptr_nxt),
        .rd_data   (buf_rd)
    );

`ifdef GNN_COLLECTOR_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC);
    logic [TCNT_W-1:0] tcnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_idx         <= '0;
            m_last        <= 1'b0;
            busy          <= 1'b0;
            ptr           <= '0;
            start_pending <= 1'b0;
`ifdef GNN_COLLECTOR_TIMEOUT_EN
            tcnt          <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ARM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef GNN_COLLECTOR_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                    end
                end

                ST_ARM: begin
                    // Word 0 bypasses the buffer so the first beat is valid
                    // straight after the capture edge.
                    if (all_ready) begin
                        state    <= ST_DRAIN;
                        in_ready <= 1'b0;
                        m_valid  <= 1'b1;
                        m_data   <= res_data[OUT_W-1:0];
                        m_idx    <= '0;
                        m_last   <= 1'b0;
                        ptr      <= '0;
                    end
`ifdef GNN_COLLECTOR_TIMEOUT_EN
                    else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
                        state       <= ST_IDLE;
                        in_ready    <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end

                ST_DRAIN: begin
                    if (start) begin
                        start_pending <= 1'b1;
                    end
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid       <= 1'b0;
                            m_data        <= '0;
                            m_idx         <= '0;
                            m_last        <= 1'b0;
                            ptr           <= '0;
                            start_pending <= 1'b0;
                            if (start_pending || start) begin
                                state    <= ST_ARM;
                                in_ready <= 1'b1;
`ifdef GNN_COLLECTOR_TIMEOUT_EN
                                tcnt     <= '0;
`endif
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            ptr    <= ptr_nxt;
                            m_idx  <= ptr_nxt;
                            m_data <= buf_rd;
                            m_last <= (ptr_nxt == IDX_W'(NUM_WORDS - 1));
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    m_valid  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gnn_result_collector.sv
//------------------------------------------------------------------------------
// Module : tb_gnn_result_collector
// Brief  : Directed self-checking bench for gnn_result_collector.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gnn_result_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [167:0] res_data;
    logic [7:0]   res_ready;
    logic         in_ready;
    logic         m_valid;
    logic         m_ready;
    logic [20:0]  m_data;
    logic [2:0]   m_idx;
    logic         m_last;
    logic         busy;
    logic         timeout_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           vals [8];
    logic [20:0]  exp_w [8];

    gnn_result_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .in_ready    (in_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_idx       (m_idx),
        .m_last      (m_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words();
        for (int i = 0; i < 8; i++) begin
            exp_w[i]             = 21'(vals[i]);
            res_data[i*21 +: 21] = 21'(vals[i]);
        end
    endtask

    task automatic start_and_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_in_ready", in_ready, 1);
        check("arm_busy", busy, 1);
        res_ready = 8'hFF;
        tick();
        res_ready = 8'h00;
        check("cap_in_ready_low", in_ready, 0);
        check("cap_m_valid", m_valid, 1);
    endtask

    // Consume beats until stop_beat words have been accepted; optionally
    // toggles m_ready and pulses start at the handshake of start_beat.
    task automatic drain(input bit toggle, input int start_beat, input int stop_beat);
        int          beat = 0;
        int          cyc  = 0;
        bit          stalled = 0;
        logic [20:0] held_d;
        logic [2:0]  held_i;
        while (beat < stop_beat && cyc < 200) begin
            if (toggle) m_ready = cyc[0];
            if (stalled) begin
                check("hold_data", m_data, held_d);
                check("hold_idx", m_idx, held_i);
                stalled = 0;
            end
            if (m_valid && m_ready) begin
                check("beat_idx", m_idx, beat);
                check("beat_data", m_data, exp_w[beat]);
                check("beat_last", m_last, (beat == 7));
                start = (beat == start_beat);
                beat++;
            end else if (m_valid) begin
                held_d  = m_data;
                held_i  = m_idx;
                stalled = 1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        if (beat < stop_beat) check("drain_bound", beat, stop_beat);
        m_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        res_data  = '0;
        res_ready = '0;
        m_ready   = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        // Nominal round
        vals = '{-6358, -4188, -6309, -4455, -6287, -4587, -6309, -4455};
        load_words();
        start_and_capture();
        check("nom_idx0_hex", m_data, 21'h1FE72A);
        drain(0, -1, 8);
        check("nom_end_valid", m_valid, 0);
        check("nom_end_in_ready", in_ready, 0);
        check("nom_end_busy", busy, 0);

        // Min round
        vals = '{default: -589824};
        load_words();
        start_and_capture();
        check("min_hex", m_data, 21'h170000);
        drain(0, -1, 8);

        // Max round, ready flags raised one at a time
        vals = '{default: 486000};
        load_words();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            res_ready[b] = 1'b1;
            tick();
            if (b < 7) begin
                check("partial_no_valid", m_valid, 0);
                check("partial_in_ready", in_ready, 1);
            end
        end
        res_ready = 8'h00;
        check("max_valid", m_valid, 1);
        check("max_hex", m_data, 21'h076A70);
        drain(0, -1, 8);

        // Backpressure
        vals = '{11, -1, 1048575, -1048576, 0, 7, -300, 12345};
        load_words();
        start_and_capture();
        drain(1, -1, 8);
        check("bp_end_valid", m_valid, 0);

        // Start during DRAIN, then reset mid-operation
        vals = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_words();
        start_and_capture();
        drain(0, 3, 8);
        check("pend_in_ready", in_ready, 1);
        check("pend_busy", busy, 1);
        check("pend_valid", m_valid, 0);
        res_ready = 8'hFF;
        tick();
        res_ready = 8'h00;
        check("pend_cap_valid", m_valid, 1);
        drain(0, -1, 4);
        check("pre_rst_idx", m_idx, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_idx", m_idx, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        check("post_rst_idle", busy, 0);

`ifdef GNN_COLLECTOR_TIMEOUT_EN
        begin
            int n = 0;
            res_ready = 8'h7F;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (in_ready && n < 200) begin
                tick();
                n++;
            end
            check("to_cycles", n, 64);
            check("to_err", timeout_err, 1);
            check("to_busy", busy, 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            check("to_sticky", timeout_err, 1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            check("to_cleared", timeout_err, 0);
            res_ready = 8'h00;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
